// File: rtl/wired_net_resolver.sv
// Two-stage valid/ready pipeline that resolves NDRV 4-state drivers of a WIDTH-bit net
// (tri/triand/trior/tri1) and counts delivered results that carry 0-vs-1 contention.
module wired_net_resolver #(
  parameter int NDRV  = 3,
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_mode,
  input  logic [NDRV*WIDTH*2-1:0]  in_drv,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH*2-1:0]       out_val,
  output logic                     out_conflict,
  output logic [CNT_W-1:0]         conflict_cnt,
  input  logic                     clr_cnt
);

  localparam logic [1:0] MODE_TRI    = 2'b00;
  localparam logic [1:0] MODE_TRIAND = 2'b01;
  localparam logic [1:0] MODE_TRIOR  = 2'b10;
  localparam logic [1:0] MODE_TRI1   = 2'b11;

  localparam logic [1:0] V0 = 2'b00;
  localparam logic [1:0] V1 = 2'b01;
  localparam logic [1:0] VZ = 2'b10;
  localparam logic [1:0] VX = 2'b11;

  logic                    r_s1_valid;
  logic [1:0]              r_s1_mode;
  logic [NDRV*WIDTH*2-1:0] r_s1_drv;
  logic                    r_s2_valid;
  logic [WIDTH*2-1:0]      r_out_val;
  logic                    r_out_conf;
  logic [CNT_W-1:0]        r_cnt;

  logic                    w_s2_load;
  logic                    w_out_fire;
  logic                    w_tri_like;
  logic [WIDTH*2-1:0]      w_res;
  logic [WIDTH-1:0]        w_bit_conf;

  assign w_s2_load  = !r_s2_valid || out_ready;
  assign w_out_fire = r_s2_valid && out_ready;
  assign w_tri_like = (r_s1_mode == MODE_TRI) || (r_s1_mode == MODE_TRI1);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic       w_has0;
      logic       w_has1;
      logic       w_hasx;
      logic [1:0] w_bit;

      always_comb begin
        w_has0 = 1'b0;
        w_has1 = 1'b0;
        w_hasx = 1'b0;
        for (int d = 0; d < NDRV; d++) begin
          case (r_s1_drv[(d*WIDTH+gi)*2 +: 2])
            V0:      w_has0 = 1'b1;
            V1:      w_has1 = 1'b1;
            VX:      w_hasx = 1'b1;
            default: ;
          endcase
        end
      end

      always_comb begin
        w_bit = VZ;
        case (r_s1_mode)
          MODE_TRIAND: w_bit = w_has0 ? V0 : (w_hasx ? VX : (w_has1 ? V1 : VZ));
          MODE_TRIOR:  w_bit = w_has1 ? V1 : (w_hasx ? VX : (w_has0 ? V0 : VZ));
          default: begin
            if (!(w_has0 || w_has1 || w_hasx))
              w_bit = (r_s1_mode == MODE_TRI1) ? V1 : VZ;
            else if (w_hasx || (w_has0 && w_has1))
              w_bit = VX;
            else
              w_bit = w_has0 ? V0 : V1;
          end
        endcase
      end

      assign w_res[gi*2 +: 2] = w_bit;
      assign w_bit_conf[gi]   = w_has0 && w_has1 && w_tri_like;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= '0;
      r_s1_drv   <= '0;
      r_s2_valid <= 1'b0;
      r_out_val  <= '0;
      r_out_conf <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_mode <= in_mode;
          r_s1_drv  <= in_drv;
        end
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_val  <= w_res;
          r_out_conf <= |w_bit_conf;
        end
      end
      // Clear has priority over a coincident conflicting delivery.
      if (clr_cnt)
        r_cnt <= '0;
      else if (w_out_fire && r_out_conf && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign in_ready     = !r_s1_valid || w_s2_load;
  assign out_valid    = r_s2_valid && !rst;
  assign out_val      = r_out_val;
  assign out_conflict = r_out_conf;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_wired_net_resolver.sv
// Directed and random bench for wired_net_resolver; a count-based resolution model and a
// result queue supply all expected values.
module tb_wired_net_resolver;
  localparam int NDRV  = 3;
  localparam int WIDTH = 2;
  localparam logic [1:0] V0 = 2'b00, V1 = 2'b01, VZ = 2'b10, VX = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst, in_valid, out_ready, clr_cnt;
  logic [1:0]              in_mode;
  logic [NDRV*WIDTH*2-1:0] in_drv;
  logic                    in_ready, out_valid, out_conflict;
  logic [WIDTH*2-1:0]      out_val;
  logic [7:0]              conflict_cnt;
  logic                    in_ready_s, out_valid_s, out_conflict_s;
  logic [WIDTH*2-1:0]      out_val_s;
  logic [1:0]              cnt_s;

  wired_net_resolver #(.NDRV(NDRV), .WIDTH(WIDTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_drv(in_drv), .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val),
    .out_conflict(out_conflict), .conflict_cnt(conflict_cnt), .clr_cnt(clr_cnt));

  wired_net_resolver #(.NDRV(NDRV), .WIDTH(WIDTH), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_mode(in_mode),
    .in_drv(in_drv), .out_valid(out_valid_s), .out_ready(out_ready), .out_val(out_val_s),
    .out_conflict(out_conflict_s), .conflict_cnt(cnt_s), .clr_cnt(clr_cnt));

  int total = 0;
  int bad   = 0;
  logic [4:0] q[$];
  int   m_cnt, m_cnt2;
  logic prev_stall = 1'b0;
  logic [4:0] prev_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Resolve by counting how many drivers hold each value on each bit.
  function automatic logic [4:0] model(input logic [1:0] mode, input logic [NDRV*WIDTH*2-1:0] drv);
    logic [3:0] v;
    logic       c;
    int n0, n1, nx, nz;
    logic [1:0] code, r;
    v = '0;
    c = 1'b0;
    for (int b = 0; b < WIDTH; b++) begin
      n0 = 0; n1 = 0; nx = 0; nz = 0;
      for (int d = 0; d < NDRV; d++) begin
        code = drv[(d*WIDTH+b)*2 +: 2];
        if (code == V0) n0++;
        else if (code == V1) n1++;
        else if (code == VX) nx++;
        else nz++;
      end
      if (mode == 2'b01)      r = (n0 > 0) ? V0 : (nx > 0) ? VX : (n1 > 0) ? V1 : VZ;
      else if (mode == 2'b10) r = (n1 > 0) ? V1 : (nx > 0) ? VX : (n0 > 0) ? V0 : VZ;
      else begin
        if (nz == NDRV)                 r = (mode == 2'b11) ? V1 : VZ;
        else if (nx > 0 || (n0 > 0 && n1 > 0)) r = VX;
        else                            r = (n0 > 0) ? V0 : V1;
        if (n0 > 0 && n1 > 0) c = 1'b1;
      end
      v[b*2 +: 2] = r;
    end
    return {c, v};
  endfunction

  task automatic put(input int d, input int b, input logic [1:0] c);
    in_drv[(d*WIDTH+b)*2 +: 2] = c;
  endtask

  task automatic all_z();
    for (int d = 0; d < NDRV; d++)
      for (int b = 0; b < WIDTH; b++) put(d, b, VZ);
  endtask

  task automatic cyc();
    logic [4:0] e;
    logic hs_conf;
    @(negedge clk);
    if (rst) begin
      q.delete();
      m_cnt = 0; m_cnt2 = 0;
      prev_stall = 1'b0;
    end else begin
      chk("cnt", conflict_cnt, m_cnt);
      chk("cnt_sat", cnt_s, m_cnt2);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", {out_conflict, out_val}, prev_out);
      end
      hs_conf = 1'b0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", out_valid, 0);
        else begin
          e = q.pop_front();
          chk("out_val", out_val, e[3:0]);
          chk("out_conf", out_conflict, e[4]);
          hs_conf = e[4];
          $display("xfer out_val=%b out_conflict=%b cnt=%0d", out_val, out_conflict, conflict_cnt);
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_mode, in_drv));
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_conflict, out_val};
      if (clr_cnt) begin
        m_cnt = 0; m_cnt2 = 0;
      end else if (hs_conf) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run1(input logic [1:0] mode, input logic [3:0] expv, input logic expc);
    int n;
    in_mode = mode;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 6) begin
      cyc();
      n++;
    end
    chk("run_valid", out_valid, 1);
    chk("run_val", out_val, expv);
    chk("run_conf", out_conflict, expc);
    cyc();
  endtask

  task automatic conflict_drv();
    all_z();
    put(0, 0, V0);
    put(1, 0, V1);
  endtask

  initial begin
    int acc, base, n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
    in_mode = 2'b00; in_drv = '0;
    m_cnt = 0; m_cnt2 = 0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cnt", conflict_cnt, 0);
    chk("rst_in_ready", in_ready, 1);

    // Latency: result appears exactly two edges after acceptance.
    all_z();
    put(1, 0, V1);
    put(0, 1, V0);
    in_mode = 2'b00; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("lat_s1_only", out_valid, 0);
    cyc();
    chk("lat_valid", out_valid, 1);
    chk("lat_val", out_val, 4'b0001);
    chk("lat_conf", out_conflict, 0);
    cyc();

    conflict_drv();
    run1(2'b00, 4'b1011, 1'b1);
    chk("cnt_after_conflict", conflict_cnt, 1);
    run1(2'b01, 4'b1000, 1'b0);
    run1(2'b10, 4'b1001, 1'b0);
    all_z();
    run1(2'b11, 4'b0101, 1'b0);
    run1(2'b00, 4'b1010, 1'b0);

    // Back-pressure: two transactions fill the pipe, then in_ready drops.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      conflict_drv();
      put(2, 1, acc[0] ? V1 : V0);
      in_mode = 2'b00; in_valid = 1'b1;
      if (in_ready) acc++;
      cyc();
    end
    chk("stall_accepted", acc, 2);
    chk("stall_in_ready", in_ready, 0);
    in_valid = 1'b0;
    base = m_cnt;
    out_ready = 1'b1;
    cyc(); cyc(); cyc();
    chk("stall_cnt_plus2", conflict_cnt, base + 2);

    // Saturation of the 2-bit counter.
    clr_cnt = 1'b1; cyc(); clr_cnt = 1'b0;
    conflict_drv();
    in_mode = 2'b11; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    in_valid = 1'b0;
    cyc(); cyc(); cyc();
    chk("sat_small", cnt_s, 3);
    chk("sat_big", conflict_cnt, 5);

    // Clear coincident with a conflicting delivery.
    in_mode = 2'b00; out_ready = 1'b0; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 6) begin
      cyc();
      n++;
    end
    chk("clr_wait", out_valid, 1);
    out_ready = 1'b1; clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    chk("clr_wins", conflict_cnt, 0);

    // Reset with both stages full discards everything.
    out_ready = 1'b0; in_valid = 1'b1;
    cyc(); cyc();
    in_valid = 1'b0;
    cyc();
    chk("full_before_rst", out_valid, 1);
    rst = 1'b1;
    cyc();
    chk("rst_flush_valid", out_valid, 0);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rst_no_output", out_valid, 0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_mode   = 2'($urandom);
      in_drv    = 12'($urandom);
      out_ready = ($urandom % 4) != 0;
      clr_cnt   = ($urandom % 20) == 0;
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("drain_empty", q.size(), 0);
    chk("drain_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wired_net_resolver.md
Name: wired_net_resolver

Overview:
- Parametrised, pipelined resolver for multi-driver 4-state nets.
- Combines NDRV drivers of a WIDTH-bit net into one resolved value, per transaction.
- Resolution type is selected per transaction: tri, triand, trior or tri1.
- Feeds the net-semantics checking path; flags and counts driver contention (0 vs 1 on one bit).

Parameters:
NDRV, 3, number of drivers on the net (>=2)
WIDTH, 4, net width in bits (>=1)
CNT_W, 8, width of saturating conflict counter

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  transaction present
in_ready  output  1  block accepts transaction this cycle
in_mode  input  2  00=tri, 01=triand, 10=trior, 11=tri1
in_drv  input  NDRV*WIDTH*2  driver d, bit b at [(d*WIDTH+b)*2 +: 2]
out_valid  output  1  resolved result present
out_ready  input  1  consumer accepts result
out_val  output  WIDTH*2  resolved net, bit b at [b*2 +: 2]
out_conflict  output  1  result contains contention on some bit
conflict_cnt  output  CNT_W  count of delivered conflicting results
clr_cnt  input  1  synchronous counter clear

Behaviour:
- Bit encoding (2 bits): 00=0, 01=1, 10=z, 11=x.
- Reset: synchronous, active-high. Clears both stage valids, out_val=0, out_conflict=0, conflict_cnt=0. in_ready=1 the cycle after reset deasserts.
- Reset mid-operation discards all in-flight transactions; no output handshake completes during or after that reset.
- Pipeline, two register stages:
  - S1 captures in_mode/in_drv.
  - S2 holds the resolved result and conflict flag.
  - Latency: 2 cycles from input handshake to out_valid, with no stall.
- Handshake, valid/ready:
  - Input accepted when in_valid & in_ready; output consumed when out_valid & out_ready.
  - S2 loads when S2 is empty or consumed this cycle.
  - S1 advances when S2 loads.
  - in_ready = !S1_valid | S1 advancing.
  - Full throughput (1 per cycle) while out_ready=1.
  - Outputs are stable while out_valid & !out_ready; no transaction is dropped or duplicated.
- Per-bit resolution over all NDRV drivers:
  - tri: all z -> z; any x -> x; both 0 and 1 present -> x with conflict; otherwise the common non-z value.
  - triand: any 0 -> 0; else any x -> x; else any 1 -> 1; else z.
  - trior: any 1 -> 1; else any x -> x; else any 0 -> 0; else z.
  - tri1: same as tri, except all z -> 1.
- out_conflict: OR over bits of the 0-and-1-present condition, in tri/tri1 modes only. triand/trior never flag.
- conflict_cnt:
  - Increments by 1 on each output handshake with out_conflict=1.
  - Saturates at 2^CNT_W-1.
  - clr_cnt sets it to 0 and wins over a same-cycle increment.
  - Unaffected by stalls.
- Width rules: resolution is purely bitwise; no carry or cross-bit interaction. Mode is carried per transaction alongside its data.

Test Plan:
- Reset, then idle: out_valid=0, conflict_cnt=0; in_ready=1 the cycle after rst falls.
- NDRV=3, WIDTH=2, mode tri; drivers bit0 = {z,1,z}, bit1 = {0,z,z} -> out_val = 2'b00_01 (bit1=0, bit0=1), out_conflict=0, 2 cycles later.
- Mode tri; bit0 = {0,1,z} -> bit0 = x (11), out_conflict=1, conflict_cnt 0->1 on handshake. Same drivers in triand -> bit0=0, no conflict; in trior -> bit0=1, no conflict.
- Mode tri1 with all drivers z -> out_val all 01 (all ones). Mode tri with all z -> all 10.
- Back-to-back conflicting inputs with out_ready held 0 for 5 cycles:
  - in_ready drops after 2 accepted transactions.
  - out_val stays stable throughout.
  - Releasing out_ready delivers both in order; conflict_cnt +2 total.
- With CNT_W=2, drive 5 conflicts -> conflict_cnt saturates at 3. clr_cnt coincident with a conflict handshake -> counter reads 0. rst asserted with both stages full -> out_valid=0 next cycle and the data is lost.
